// File: rtl/game_status_checker.sv
// Flood-it style game status checker: counts moves and scans the board for uniform colour after each move.
// Optional macro GAME_MOVE_LIMIT_EN enables loss detection against move_limit_i; otherwise game_lost_o is constant 0.
module game_status_checker #(
  parameter int unsigned MAX_SIZE = 26,
  parameter int unsigned MOVE_W   = 6
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [4:0]        size_i,
  input  logic [MOVE_W-1:0] move_limit_i,
  input  logic              started_game_i,
  input  logic              changing_color_i,
  output logic [4:0]        rd_row_o,
  output logic [4:0]        rd_col_o,
  input  logic [2:0]        rd_color_i,
  output logic [MOVE_W-1:0] move_count_o,
  output logic              scan_busy_o,
  output logic              status_valid_o,
  output logic              game_won_o,
  output logic              game_lost_o
);

  localparam int unsigned DIM_W = 5;
  localparam int unsigned COL_W = 3;
  localparam logic [MOVE_W-1:0] CNT_MAX = {MOVE_W{1'b1}};

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_e;

  state_e            state_q, state_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic [DIM_W-1:0]  col_q, col_d;
  logic [COL_W-1:0]  ref_q, ref_d;
  logic [MOVE_W-1:0] count_q, count_d;
  logic              won_q, won_d;
  logic              lost_q, lost_d;
  logic              pend_q, pend_d;
  logic              chg_q;

  logic             move_ok;
  logic             size_bad;
  logic             first_cell;
  logic             last_cell;
  logic             mismatch;
  logic             limit_hit;
  logic [DIM_W-1:0] size_m1;

  // A move is the falling edge of changing_color_i; ignored once the game is decided or being restarted.
  assign move_ok    = chg_q && !changing_color_i && !started_game_i && !won_q && !lost_q;
  assign size_bad   = (size_i == '0) || (32'(size_i) > MAX_SIZE);
  assign size_m1    = size_i - DIM_W'(1);
  assign first_cell = (row_q == '0) && (col_q == '0);
  assign last_cell  = (row_q == size_m1) && (col_q == size_m1);
  assign mismatch   = !first_cell && (rd_color_i != ref_q);

`ifdef GAME_MOVE_LIMIT_EN
  assign limit_hit = (count_q >= move_limit_i);
`else
  logic unused_move_limit;
  assign unused_move_limit = ^move_limit_i;
  assign limit_hit         = 1'b0;
`endif

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      ref_q   <= '0;
      count_q <= '0;
      won_q   <= 1'b0;
      lost_q  <= 1'b0;
      pend_q  <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ref_q   <= ref_d;
      count_q <= count_d;
      won_q   <= won_d;
      lost_q  <= lost_d;
      pend_q  <= pend_d;
      chg_q   <= changing_color_i;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    ref_d   = ref_q;
    count_d = count_q;
    won_d   = won_q;
    lost_d  = lost_q;
    pend_d  = pend_q;

    if (move_ok) begin
      if (count_q != CNT_MAX) begin
        count_d = count_q + MOVE_W'(1);
      end
      if (state_q == SCAN) begin
        pend_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        row_d = '0;
        col_d = '0;
        if (move_ok || pend_q) begin
          state_d = SCAN;
          pend_d  = pend_q && move_ok;
        end
      end
      SCAN: begin
        if (first_cell) begin
          ref_d = rd_color_i;
        end
        // Verdicts are latched on entry to REPORT so the flags line up with status_valid_o.
        if (size_bad || mismatch) begin
          state_d = REPORT;
          row_d   = '0;
          col_d   = '0;
          if (!won_q) begin
            lost_d = lost_q || limit_hit;
          end
        end else if (last_cell) begin
          state_d = REPORT;
          row_d   = '0;
          col_d   = '0;
          if (!lost_q) begin
            won_d = 1'b1;
          end
        end else if (col_q == size_m1) begin
          col_d = '0;
          row_d = row_q + DIM_W'(1);
        end else begin
          col_d = col_q + DIM_W'(1);
        end
      end
      REPORT: begin
        state_d = pend_q ? SCAN : IDLE;
        pend_d  = move_ok;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (started_game_i) begin
      state_d = IDLE;
      row_d   = '0;
      col_d   = '0;
      count_d = '0;
      won_d   = 1'b0;
      lost_d  = 1'b0;
      pend_d  = 1'b0;
    end
  end

  assign rd_row_o       = row_q;
  assign rd_col_o       = col_q;
  assign move_count_o   = count_q;
  assign scan_busy_o    = (state_q != IDLE);
  assign status_valid_o = (state_q == REPORT);
  assign game_won_o     = won_q;
  assign game_lost_o    = lost_q;

endmodule

// File: tb/tb_game_status_checker.sv
// Directed self-checking bench for game_status_checker; expectations follow the GAME_MOVE_LIMIT_EN build setting.
module tb_game_status_checker;

  localparam int unsigned MOVE_W = 6;
`ifdef GAME_MOVE_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [4:0]        size;
  logic [MOVE_W-1:0] limit;
  logic              sg;
  logic              cc;
  logic [4:0]        rd_row;
  logic [4:0]        rd_col;
  logic [2:0]        rd_color;
  logic [MOVE_W-1:0] count;
  logic              busy;
  logic              valid;
  logic              won;
  logic              lost;

  int checks = 0;
  int errors = 0;
  int b;
  int v;

  logic [2:0] board [0:25][0:25];

  game_status_checker #(.MAX_SIZE(26), .MOVE_W(MOVE_W)) dut (
    .clock_i         (clk),
    .reset_i         (rst),
    .size_i          (size),
    .move_limit_i    (limit),
    .started_game_i  (sg),
    .changing_color_i(cc),
    .rd_row_o        (rd_row),
    .rd_col_o        (rd_col),
    .rd_color_i      (rd_color),
    .move_count_o    (count),
    .scan_busy_o     (busy),
    .status_valid_o  (valid),
    .game_won_o      (won),
    .game_lost_o     (lost)
  );

  always #5 clk = ~clk;

  always_comb begin
    rd_color = 3'd0;
    if (rd_row < 5'd26 && rd_col < 5'd26) rd_color = board[rd_row][rd_col];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_move();
    cc = 1'b1;
    tick();
    cc = 1'b0;
    tick();
  endtask

  task automatic clear_game();
    sg = 1'b1;
    tick();
    sg = 1'b0;
    tick();
  endtask

  task automatic fill(input logic [2:0] c);
    for (int i = 0; i < 26; i++)
      for (int j = 0; j < 26; j++)
        board[i][j] = c;
  endtask

  // Counts busy cycles and verdict pulses until the scanner returns to idle (bounded).
  task automatic run_scan(output int nbusy, output int nvalid);
    nbusy  = 0;
    nvalid = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!busy) break;
      nbusy++;
      if (valid) nvalid++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; cc = 1'b0; sg = 1'b0; size = 5'd6; limit = 6'd25;
    fill(3'd3);
    tick(); tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_won", 32'(won), 0);
    chk("rst_lost", 32'(lost), 0);
    chk("rst_addr", 32'({rd_row, rd_col}), 0);
    rst = 1'b0;
    tick();
    chk("idle_quiet", 32'(busy), 0);

    // Uniform 6x6 board
    do_move();
    chk("u6_count", 32'(count), 1);
    chk("u6_start_addr", 32'({rd_row, rd_col}), 0);
    run_scan(b, v);
    chk("u6_busy", b, 37);
    chk("u6_valid", v, 1);
    chk("u6_won", 32'(won), 1);
    chk("u6_lost", 32'(lost), 0);
    chk("u6_idle_addr", 32'({rd_row, rd_col}), 0);

    // Early exit at (2,4): linear index 16
    clear_game();
    chk("clr_won", 32'(won), 0);
    chk("clr_count", 32'(count), 0);
    board[2][4] = 3'd5;
    do_move();
    repeat (8) tick();
    chk("ee_row", 32'(rd_row), 1);
    chk("ee_col", 32'(rd_col), 2);
    run_scan(b, v);
    chk("ee_busy_rest", b, 10);
    chk("ee_valid", v, 1);
    chk("ee_won", 32'(won), 0);
    chk("ee_lost", 32'(lost), 0);

    // Move limit of 3 on a non-uniform board
    clear_game();
    limit = 6'd3;
    for (int m = 1; m <= 3; m++) begin
      do_move();
      run_scan(b, v);
      chk("lim_valid", v, 1);
      chk("lim_count", 32'(count), 32'(m));
    end
    chk("lim_lost", 32'(lost), 32'(LIMIT_EN));
    chk("lim_won", 32'(won), 0);
    do_move();
    chk("lim_4th_count", 32'(count), LIMIT_EN ? 3 : 4);
    chk("lim_4th_busy", 32'(busy), LIMIT_EN ? 0 : 1);
    run_scan(b, v);

    // Illegal sizes exit at once; size 1 is trivially uniform
    clear_game();
    limit = 6'd25;
    fill(3'd2);
    size = 5'd0;
    do_move();
    run_scan(b, v);
    chk("sz0_busy", b, 2);
    chk("sz0_valid", v, 1);
    chk("sz0_won", 32'(won), 0);
    size = 5'd27;
    do_move();
    run_scan(b, v);
    chk("sz27_busy", b, 2);
    chk("sz27_won", 32'(won), 0);
    size = 5'd1;
    do_move();
    run_scan(b, v);
    chk("sz1_busy", b, 2);
    chk("sz1_won", 32'(won), 1);
    chk("sz1_count", 32'(count), 3);

    // Second move during a 26x26 scan chains a second scan
    clear_game();
    size = 5'd26;
    fill(3'd1);
    do_move();
    repeat (99) tick();
    do_move();
    chk("chain_count", 32'(count), 2);
    run_scan(b, v);
    chk("chain_busy", b, 1253);
    chk("chain_valid", v, 2);
    chk("chain_won", 32'(won), 1);

    // Restart aborts a scan in progress
    clear_game();
    board[0][1] = 3'd4;
    repeat (4) begin
      do_move();
      run_scan(b, v);
    end
    board[0][1] = 3'd1;
    do_move();
    chk("abort_pre_count", 32'(count), 5);
    repeat (200) tick();
    chk("abort_pre_busy", 32'(busy), 1);
    sg = 1'b1;
    tick();
    chk("abort_busy", 32'(busy), 0);
    chk("abort_count", 32'(count), 0);
    chk("abort_flags", 32'({won, lost}), 0);
    chk("abort_valid", 32'(valid), 0);
    chk("abort_addr", 32'({rd_row, rd_col}), 0);
    sg = 1'b0;
    v = 0;
    repeat (20) begin
      tick();
      if (valid || busy) v++;
    end
    chk("abort_quiet", v, 0);

    // Asynchronous reset mid-scan
    clear_game();
    limit = 6'd0;
    do_move();
    repeat (50) tick();
    chk("ar_pre_addr", 32'({rd_row, rd_col}), 32'({5'd1, 5'd24}));
    #3 rst = 1'b1;
    #1;
    chk("ar_busy", 32'(busy), 0);
    chk("ar_count", 32'(count), 0);
    chk("ar_addr", 32'({rd_row, rd_col}), 0);
    chk("ar_flags", 32'({won, lost, valid}), 0);
    tick();
    rst = 1'b0;
    v = 0;
    repeat (10) begin
      tick();
      if (valid) v++;
    end
    chk("ar_no_verdict", v, 0);
    chk("ar_lost", 32'(lost), 0);
    board[0][1] = 3'd6;
    do_move();
    run_scan(b, v);
    chk("ar_scan_valid", v, 1);
    chk("ar_limit0_lost", 32'(lost), 32'(LIMIT_EN));
    chk("ar_limit0_won", 32'(won), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_status_checker.md
GAME_STATUS_CHECKER -- requirements
Module: game_status_checker

Interface
REQ-001 Parameter MAX_SIZE, default 26, SHALL set the largest legal board dimension.
REQ-002 Parameter MOVE_W, default 6, SHALL set the width of the move counter and of MOVE_LIMIT.
REQ-003 CLOCK  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 RESET  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 SIZE  in  5  SHALL give the board dimension (SIZE x SIZE); legal values are 1..MAX_SIZE.
REQ-006 MOVE_LIMIT  in  MOVE_W  SHALL give the maximum number of moves allowed.
REQ-007 STARTED_GAME  in  1  SHALL signal that the game logic has loaded a new board; it is level-sensitive.
REQ-008 CHANGING_COLOR  in  1  SHALL be high while a flood fill runs; its falling edge marks one completed move.
REQ-009 RD_ROW  out  5  SHALL be the row address of the board read port.
REQ-010 RD_COL  out  5  SHALL be the column address of the board read port.
REQ-011 RD_COLOR  in  3  SHALL be the cell colour at (RD_ROW, RD_COL), returned combinationally in the same cycle.
REQ-012 MOVE_COUNT  out  MOVE_W  SHALL be the number of completed moves.
REQ-013 SCAN_BUSY  out  1  SHALL be high while the state is SCAN or REPORT.
REQ-014 STATUS_VALID  out  1  SHALL pulse high for one cycle when a scan verdict is published.
REQ-015 GAME_WON  out  1  SHALL be the sticky win flag.
REQ-016 GAME_LOST  out  1  SHALL be the sticky loss flag.

Function
REQ-017 Edge detect: the block SHALL register CHANGING_COLOR each cycle; a move SHALL complete when the registered value is 1 and the input is 0.
REQ-018 On each completed move, while GAME_WON=0 and GAME_LOST=0, MOVE_COUNT SHALL increment by 1 and saturate at 2^MOVE_W-1.
REQ-019 Completed moves while GAME_WON=1 or GAME_LOST=1 SHALL be ignored: no count change and no scan.
REQ-020 FSM states SHALL be IDLE, SCAN and REPORT.
REQ-021 IDLE -> SCAN SHALL occur on a completed move (REQ-018), or on a pending move (REQ-025); the scan address SHALL reset to (0,0).
REQ-022 In SCAN the block SHALL visit one cell per cycle in row-major order, RD_COL fastest, from (0,0) to (SIZE-1,SIZE-1).
- The colour at (0,0) SHALL be captured as the reference colour.
- On the first cell whose colour differs from the reference, the block SHALL go to REPORT with uniform=0 (early exit).
- When the last cell matches, the block SHALL go to REPORT with uniform=1.
REQ-023 Scan latency SHALL be: a uniform board takes SIZE*SIZE cycles in SCAN plus 1 cycle in REPORT; an early exit at linear index k takes k+1 cycles in SCAN plus 1 cycle in REPORT.
REQ-024 REPORT SHALL last one cycle and SHALL raise STATUS_VALID.
- If uniform=1, GAME_WON SHALL be set.
- Otherwise, if MOVE_COUNT >= MOVE_LIMIT, GAME_LOST SHALL be set.
- Otherwise, no flag SHALL change.
- GAME_WON and GAME_LOST SHALL never both be 1.
REQ-025 A completed move during SCAN or REPORT SHALL increment MOVE_COUNT (subject to REQ-018) and set a pending flag; REPORT SHALL then go to SCAN and clear the pending flag; otherwise REPORT SHALL go to IDLE.
REQ-026 If SIZE is 0 or greater than MAX_SIZE, SCAN SHALL exit immediately with uniform=0.
REQ-027 In IDLE, RD_ROW and RD_COL SHALL be 0.
REQ-028 STARTED_GAME=1 SHALL take priority over all other events. It SHALL:
- clear MOVE_COUNT, GAME_WON, GAME_LOST and the pending flag;
- abort any scan;
- force IDLE, with no STATUS_VALID.

Reset
REQ-029 While RESET=1, the block SHALL hold the following values: state IDLE, MOVE_COUNT=0, GAME_WON=0, GAME_LOST=0, STATUS_VALID=0, SCAN_BUSY=0, RD_ROW=0, RD_COL=0, pending flag=0, registered CHANGING_COLOR=0.
REQ-030 A reset asserted mid-scan SHALL abandon the scan, and no verdict SHALL be published.

Configuration
REQ-031 With macro GAME_MOVE_LIMIT_EN defined, loss detection SHALL operate as in REQ-024.
REQ-032 Without GAME_MOVE_LIMIT_EN, GAME_LOST SHALL be constant 0, MOVE_LIMIT SHALL be ignored, and all other behaviour SHALL be unchanged.

Verification
REQ-033 SIZE=6, all 36 cells colour 3, one CHANGING_COLOR 1->0 -> MOVE_COUNT=1; SCAN_BUSY high for 37 cycles; STATUS_VALID pulses once; GAME_WON=1.
REQ-034 SIZE=6, cell (2,4) differs, all others equal -> early exit after 17 SCAN cycles; STATUS_VALID pulses; GAME_WON=0; GAME_LOST=0 (MOVE_LIMIT=25).
REQ-035 MOVE_LIMIT=3, non-uniform board, three moves -> GAME_LOST=1 after the third scan; a fourth move leaves MOVE_COUNT=3 and starts no scan.
REQ-036 SIZE=26, uniform board, second move issued 100 cycles into the first scan -> MOVE_COUNT=2; two consecutive verdicts (two STATUS_VALID pulses), with REPORT going directly to SCAN.
REQ-037 STARTED_GAME pulsed 200 cycles into a SIZE=26 scan with MOVE_COUNT=5 -> next cycle IDLE, MOVE_COUNT=0, flags 0, no STATUS_VALID.
REQ-038 RESET asserted asynchronously mid-scan with GAME_MOVE_LIMIT_EN undefined -> all outputs 0 immediately; GAME_LOST stays 0 afterwards, even with MOVE_LIMIT=0.
